// File: rtl/tiny_riscv_pkg.sv
// Shared definitions for the tiny_riscv data-memory path.
// Provides default widths and the store-buffer entry layout.
package tiny_riscv_pkg;

    localparam int XLEN     = 32;
    localparam int DMEM_AW  = 10;
    localparam int SB_DEPTH = 4;

    typedef struct packed {
        logic [DMEM_AW-1:0] addr;
        logic [XLEN-1:0]    data;
    } sb_entry_t;

endpackage

// File: rtl/dmem_store_buffer_fifo.sv
// Circular store FIFO with count, head read and a per-slot occupancy mask.
// A push while full is accepted only when a pop happens in the same cycle.
module sb_fifo
    import tiny_riscv_pkg::*;
#(
    parameter int  DEPTH   = SB_DEPTH,
    parameter type entry_t = sb_entry_t
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  entry_t                     push_data_i,
    output entry_t                     head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [$clog2(DEPTH)-1:0]   head_ptr_o,
    output entry_t                     entries_o [DEPTH],
    output logic [DEPTH-1:0]           valid_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   head_q, tail_q;
    logic [CW-1:0]   count_q, count_d;
    logic            do_push_s, do_pop_s;

    assign full_o     = (count_q == CW'(DEPTH));
    assign empty_o    = (count_q == {CW{1'b0}});
    assign do_pop_s   = pop_i && !empty_o;
    assign do_push_s  = push_i && (!full_o || do_pop_s);
    assign head_o     = mem_q[head_q];
    assign count_o    = count_q;
    assign head_ptr_o = head_q;
    assign entries_o  = mem_q;

    // Next occupancy count.
    always_comb begin
        count_d = count_q;
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Slot i is occupied when its distance from head is below count; pointer math wraps.
    always_comb begin
        logic [PW-1:0] off_s;
        off_s   = {PW{1'b0}};
        valid_o = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            off_s      = PW'(i) - head_q;
            valid_o[i] = ({1'b0, off_s} < count_q);
        end
    end

    // Pointer, count and storage registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= {PW{1'b0}};
            tail_q  <= {PW{1'b0}};
            count_q <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            if (do_push_s) begin
                mem_q[tail_q] <= push_data_i;
                tail_q        <= tail_q + PW'(1);
            end
            if (do_pop_s) begin
                head_q <= head_q + PW'(1);
            end
        end
    end

endmodule

// File: rtl/dmem_store_buffer.sv
// Data-memory front end: buffers core stores, drains them in load-free cycles,
// and returns loads one cycle later with forwarding from pending/same-cycle stores.
module dmem_store_buffer
    import tiny_riscv_pkg::*;
#(
    parameter int SB_DEPTH = tiny_riscv_pkg::SB_DEPTH,
    parameter int AW       = DMEM_AW,
    parameter int DW       = XLEN
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          dmem_rd,
    input  logic [31:0]   dmem_raddr,
    output logic [DW-1:0] dmem_rdata,
    input  logic          dmem_wr,
    input  logic [31:0]   dmem_waddr,
    input  logic [DW-1:0] dmem_wdata,
    output logic          sram_cs,
    output logic          sram_we,
    output logic [AW-1:0] sram_addr,
    output logic [DW-1:0] sram_wdata,
    input  logic [DW-1:0] sram_rdata,
    output logic          sb_empty,
    output logic          sb_overflow
);

    localparam int PW = $clog2(SB_DEPTH);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } entry_t;

    logic [AW-1:0]       rd_word_s, wr_word_s;
    entry_t              push_entry_s, head_s;
    entry_t              entries_s [SB_DEPTH];
    logic [SB_DEPTH-1:0] valid_s;
    logic [PW-1:0]       head_ptr_s;
    logic [PW:0]         count_s;
    logic                full_s, empty_s, push_s, pop_s, drop_s;
    logic                hit_s;
    logic [DW-1:0]       hit_data_s;
    logic                sel_sram_q, sel_sram_d;
    logic [DW-1:0]       rdata_q, rdata_d;
    logic                ovf_q;
    logic                unused_bits_s;

    assign rd_word_s    = dmem_raddr[AW+1:2];
    assign wr_word_s    = dmem_waddr[AW+1:2];
    assign push_entry_s = '{addr: wr_word_s, data: dmem_wdata};

    // A load blocks the drain, so a store into a full buffer alongside a load has nowhere to go.
    assign drop_s   = dmem_wr && dmem_rd && full_s;
    assign push_s   = dmem_wr && !drop_s;
    assign pop_s    = !dmem_rd && !empty_s;
    assign sb_empty = empty_s;
    assign sb_overflow = ovf_q;
    assign unused_bits_s = ^{dmem_raddr[31:AW+2], dmem_raddr[1:0],
                             dmem_waddr[31:AW+2], dmem_waddr[1:0], count_s};

    sb_fifo #(
        .DEPTH   (SB_DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push_s),
        .pop_i       (pop_s),
        .push_data_i (push_entry_s),
        .head_o      (head_s),
        .full_o      (full_s),
        .empty_o     (empty_s),
        .count_o     (count_s),
        .head_ptr_o  (head_ptr_s),
        .entries_o   (entries_s),
        .valid_o     (valid_s)
    );

    // Youngest-match search: walk oldest to youngest so later hits override earlier ones.
    always_comb begin
        logic [PW-1:0] idx_s;
        idx_s      = {PW{1'b0}};
        hit_s      = 1'b0;
        hit_data_s = {DW{1'b0}};
        for (int k = 0; k < SB_DEPTH; k++) begin
            idx_s = head_ptr_s + PW'(k);
            if (valid_s[idx_s] && (entries_s[idx_s].addr == rd_word_s)) begin
                hit_s      = 1'b1;
                hit_data_s = entries_s[idx_s].data;
            end else begin
                hit_s      = hit_s;
            end
        end
    end

    // SRAM port arbitration: load first, then drain, otherwise idle; nothing during reset.
    always_comb begin
        sram_cs    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = rd_word_s;
        sram_wdata = head_s.data;
        if (rst) begin
            sram_cs = 1'b0;
        end else if (dmem_rd) begin
            sram_cs = 1'b1;
        end else if (!empty_s) begin
            sram_cs   = 1'b1;
            sram_we   = 1'b1;
            sram_addr = head_s.addr;
        end else begin
            sram_cs = 1'b0;
        end
    end

    // Load-return source select; an SRAM result is captured once so it holds after the load.
    always_comb begin
        sel_sram_d = sel_sram_q;
        rdata_d    = rdata_q;
        if (dmem_rd) begin
            if (dmem_wr && (wr_word_s == rd_word_s)) begin
                sel_sram_d = 1'b0;
                rdata_d    = dmem_wdata;
            end else if (hit_s) begin
                sel_sram_d = 1'b0;
                rdata_d    = hit_data_s;
            end else begin
                sel_sram_d = 1'b1;
            end
        end else if (sel_sram_q) begin
            sel_sram_d = 1'b0;
            rdata_d    = sram_rdata;
        end else begin
            sel_sram_d = 1'b0;
        end
    end

    assign dmem_rdata = sel_sram_q ? sram_rdata : rdata_q;

    // Load-return and sticky overflow registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_sram_q <= 1'b0;
            rdata_q    <= {DW{1'b0}};
            ovf_q      <= 1'b0;
        end else begin
            sel_sram_q <= sel_sram_d;
            rdata_q    <= rdata_d;
            ovf_q      <= ovf_q | drop_s;
        end
    end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Directed bench for dmem_store_buffer with a behavioural SRAM whose untouched words read 0xC0DE0000+addr.
module tb_dmem_store_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dmem_rd = 1'b0;
    logic [31:0] dmem_raddr = 32'h0;
    logic [31:0] dmem_rdata;
    logic        dmem_wr = 1'b0;
    logic [31:0] dmem_waddr = 32'h0;
    logic [31:0] dmem_wdata = 32'h0;
    logic        sram_cs, sram_we;
    logic [9:0]  sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata = 32'h0;
    logic        sb_empty, sb_overflow;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [1024];
    logic        mem_ready = 1'b0;

    always #5 clk = ~clk;

    dmem_store_buffer dut (
        .clk         (clk),
        .rst         (rst),
        .dmem_rd     (dmem_rd),
        .dmem_raddr  (dmem_raddr),
        .dmem_rdata  (dmem_rdata),
        .dmem_wr     (dmem_wr),
        .dmem_waddr  (dmem_waddr),
        .dmem_wdata  (dmem_wdata),
        .sram_cs     (sram_cs),
        .sram_we     (sram_we),
        .sram_addr   (sram_addr),
        .sram_wdata  (sram_wdata),
        .sram_rdata  (sram_rdata),
        .sb_empty    (sb_empty),
        .sb_overflow (sb_overflow)
    );

    // Single-port synchronous SRAM; read data holds until the next read.
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'hC0DE0000 + i;
            mem_ready <= 1'b1;
        end else if (sram_cs) begin
            if (sram_we) mem[sram_addr] <= sram_wdata;
            else         sram_rdata <= mem[sram_addr];
        end
    end

    typedef struct {
        logic        rd;
        logic [31:0] ra;
        logic        wr;
        logic [31:0] wa;
        logic [31:0] wd;
        logic        cs;
        logic        we;
        logic [9:0]  sa;
        logic [31:0] swd;
        logic [31:0] rdata;
        logic        empty;
        logic        ovf;
    } vec_t;

    vec_t v [27];

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%0d]: got %h, want %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic [31:0] ra, input logic wr,
                         input logic [31:0] wa, input logic [31:0] wd);
        @(posedge clk);
        #1;
        dmem_rd = rd; dmem_raddr = ra; dmem_wr = wr; dmem_waddr = wa; dmem_wdata = wd;
    endtask

    initial begin
        //          rd    ra          wr    wa          wd            cs    we    sa      swd           rdata         empty ovf
        // store 0x100, drain, load back from SRAM
        v[0]  = '{1'b0, 32'h0,      1'b1, 32'h100,    32'hDEADBEEF, 1'b0, 1'b0, 10'h0,   32'h0,        32'h0,        1'b1, 1'b0};
        v[1]  = '{1'b0, 32'h0,      1'b0, 32'h0,      32'h0,        1'b1, 1'b1, 10'h40,  32'hDEADBEEF, 32'h0,        1'b0, 1'b0};
        v[2]  = '{1'b1, 32'h100,    1'b0, 32'h0,      32'h0,        1'b1, 1'b0, 10'h40,  32'h0,        32'h0,        1'b1, 1'b0};
        v[3]  = '{1'b0, 32'h0,      1'b0, 32'h0,      32'h0,        1'b0, 1'b0, 10'h0,   32'h0,        32'hDEADBEEF, 1'b1, 1'b0};
        // same-cycle store/load forwarding
        v[4]  = '{1'b1, 32'h200,    1'b1, 32'h200,    32'h11111111, 1'b1, 1'b0, 10'h80,  32'h0,        32'hDEADBEEF, 1'b1, 1'b0};
        v[5]  = '{1'b0, 32'h0,      1'b0, 32'h0,      32'h0,        1'b1, 1'b1, 10'h80,  32'h11111111, 32'h11111111, 1'b0, 1'b0};
        // youngest-entry forwarding, in-order drain
        v[6]  = '{1'b0, 32'h0,      1'b1, 32'h300,    32'h1,        1'b0, 1'b0, 10'h0,   32'h0,        32'h11111111, 1'b1, 1'b0};
        v[7]  = '{1'b1, 32'h104,    1'b1, 32'h300,    32'h2,        1'b1, 1'b0, 10'h41,  32'h0,        32'h11111111, 1'b0, 1'b0};
        v[8]  = '{1'b1, 32'h300,    1'b0, 32'h0,      32'h0,        1'b1, 1'b0, 10'hC0,  32'h0,        32'hC0DE0041, 1'b0, 1'b0};
        v[9]  = '{1'b0, 32'h0,      1'b0, 32'h0,      32'h0,        1'b1, 1'b1, 10'hC0,  32'h1,        32'h2,        1'b0, 1'b0};
        v[10] = '{1'b0, 32'h0,      1'b0, 32'h0,      32'h0,        1'b1, 1'b1, 10'hC0,  32'h2,        32'h2,        1'b0, 1'b0};
        v[11] = '{1'b0, 32'h0,      1'b0, 32'h0,      32'h0,        1'b0, 1'b0, 10'h0,   32'h0,        32'h2,        1'b1, 1'b0};
        // fill with loads blocking the drain, then overflow on the fifth store
        v[12] = '{1'b1, 32'h0,      1'b1, 32'h400,    32'hA0,       1'b1, 1'b0, 10'h0,   32'h0,        32'h2,        1'b1, 1'b0};
        v[13] = '{1'b1, 32'h0,      1'b1, 32'h404,    32'hA1,       1'b1, 1'b0, 10'h0,   32'h0,        32'hC0DE0000, 1'b0, 1'b0};
        v[14] = '{1'b1, 32'h0,      1'b1, 32'h408,    32'hA2,       1'b1, 1'b0, 10'h0,   32'h0,        32'hC0DE0000, 1'b0, 1'b0};
        v[15] = '{1'b1, 32'h0,      1'b1, 32'h40C,    32'hA3,       1'b1, 1'b0, 10'h0,   32'h0,        32'hC0DE0000, 1'b0, 1'b0};
        v[16] = '{1'b1, 32'h0,      1'b1, 32'h410,    32'hA4,       1'b1, 1'b0, 10'h0,   32'h0,        32'hC0DE0000, 1'b0, 1'b0};
        v[17] = '{1'b0, 32'h0,      1'b0, 32'h0,      32'h0,        1'b1, 1'b1, 10'h100, 32'hA0,       32'hC0DE0000, 1'b0, 1'b1};
        v[18] = '{1'b0, 32'h0,      1'b0, 32'h0,      32'h0,        1'b1, 1'b1, 10'h101, 32'hA1,       32'hC0DE0000, 1'b0, 1'b1};
        v[19] = '{1'b0, 32'h0,      1'b0, 32'h0,      32'h0,        1'b1, 1'b1, 10'h102, 32'hA2,       32'hC0DE0000, 1'b0, 1'b1};
        v[20] = '{1'b0, 32'h0,      1'b0, 32'h0,      32'h0,        1'b1, 1'b1, 10'h103, 32'hA3,       32'hC0DE0000, 1'b0, 1'b1};
        v[21] = '{1'b1, 32'h410,    1'b0, 32'h0,      32'h0,        1'b1, 1'b0, 10'h104, 32'h0,        32'hC0DE0000, 1'b1, 1'b1};
        v[22] = '{1'b0, 32'h0,      1'b0, 32'h0,      32'h0,        1'b0, 1'b0, 10'h0,   32'h0,        32'hC0DE0104, 1'b1, 1'b1};
        // upper address bits alias: 0x1000 is word 0
        v[23] = '{1'b0, 32'h0,      1'b1, 32'h1000,   32'hA5A5A5A5, 1'b0, 1'b0, 10'h0,   32'h0,        32'hC0DE0104, 1'b1, 1'b1};
        v[24] = '{1'b0, 32'h0,      1'b0, 32'h0,      32'h0,        1'b1, 1'b1, 10'h0,   32'hA5A5A5A5, 32'hC0DE0104, 1'b0, 1'b1};
        v[25] = '{1'b1, 32'h0,      1'b0, 32'h0,      32'h0,        1'b1, 1'b0, 10'h0,   32'h0,        32'hC0DE0104, 1'b1, 1'b1};
        v[26] = '{1'b0, 32'h0,      1'b0, 32'h0,      32'h0,        1'b0, 1'b0, 10'h0,   32'h0,        32'hA5A5A5A5, 1'b1, 1'b1};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_cs", -1, {31'h0, sram_cs}, 32'h0);
        check("reset_empty", -1, {31'h0, sb_empty}, 32'h1);
        check("reset_ovf", -1, {31'h0, sb_overflow}, 32'h0);
        check("reset_rdata", -1, dmem_rdata, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 27; i++) begin
            drive(v[i].rd, v[i].ra, v[i].wr, v[i].wa, v[i].wd);
            @(negedge clk);
            check("sram_cs", i, {31'h0, sram_cs}, {31'h0, v[i].cs});
            if (v[i].cs) begin
                check("sram_we", i, {31'h0, sram_we}, {31'h0, v[i].we});
                check("sram_addr", i, {22'h0, sram_addr}, {22'h0, v[i].sa});
                if (v[i].we) check("sram_wdata", i, sram_wdata, v[i].swd);
            end
            check("dmem_rdata", i, dmem_rdata, v[i].rdata);
            check("sb_empty", i, {31'h0, sb_empty}, {31'h0, v[i].empty});
            check("sb_overflow", i, {31'h0, sb_overflow}, {31'h0, v[i].ovf});
        end

        // Reset with three pending stores while a drain write is in progress.
        drive(1'b1, 32'h600, 1'b1, 32'h500, 32'hB0);
        drive(1'b1, 32'h600, 1'b1, 32'h504, 32'hB1);
        drive(1'b1, 32'h600, 1'b1, 32'h508, 32'hB2);
        drive(1'b0, 32'h0,   1'b0, 32'h0,   32'h0);
        @(negedge clk);
        check("drain_cs", 100, {31'h0, sram_cs}, 32'h1);
        check("drain_we", 100, {31'h0, sram_we}, 32'h1);
        check("drain_addr", 100, {22'h0, sram_addr}, 32'h140);
        #1 rst = 1'b1;
        #1;
        check("rst_cs", 101, {31'h0, sram_cs}, 32'h0);
        check("rst_empty", 101, {31'h0, sb_empty}, 32'h1);
        check("rst_ovf", 101, {31'h0, sb_overflow}, 32'h0);
        check("rst_rdata", 101, dmem_rdata, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 32'h500, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 32'h508, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("post_rst_load0", 102, dmem_rdata, 32'hC0DE0140);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("post_rst_load2", 103, dmem_rdata, 32'hC0DE0142);
        check("post_rst_empty", 103, {31'h0, sb_empty}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
